// File: rtl/frame_axi_writer.sv
// Packs RGB565 pixels 16-to-a-word, buffers them in a show-ahead FIFO and writes them
// to DDR3 as fixed-length AXI bursts at linear per-frame addresses.
module frame_axi_writer #(
    parameter int unsigned BURST_LEN   = 8,
    parameter int unsigned FIFO_DEPTH  = 32,
    parameter logic [27:0] BASE_ADDR   = 28'h0000000,
    parameter int unsigned ADDR_INC    = 8,
    parameter int unsigned FRAME_WORDS = 57600,
    parameter logic [3:0]  AXI_ID      = 4'h0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         enable,
    input  logic         frame_start,
    input  logic         pix_valid,
    input  logic [15:0]  pix_data,
    output logic [27:0]  axi_awaddr,
    output logic         axi_awuser_ap,
    output logic [3:0]   axi_awuser_id,
    output logic [3:0]   axi_awlen,
    output logic         axi_awvalid,
    input  logic         axi_awready,
    output logic [255:0] axi_wdata,
    output logic [31:0]  axi_wstrb,
    input  logic         axi_wready,
    output logic         overflow,
    output logic         frame_done
);

    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned IdxW = $clog2(FRAME_WORDS + 1);

    localparam logic [PtrW-1:0] PtrOne   = PtrW'(1);
    localparam logic [CntW-1:0] BurstCnt = CntW'(BURST_LEN);
    localparam logic [CntW-1:0] DepthCnt = CntW'(FIFO_DEPTH);
    localparam logic [3:0]      LastBeat = 4'(BURST_LEN - 1);
    localparam logic [IdxW-1:0] BurstIdx = IdxW'(BURST_LEN);
    localparam logic [IdxW-1:0] FrameIdx = IdxW'(FRAME_WORDS);
    localparam logic [27:0]     AddrInc  = 28'(ADDR_INC);

    typedef enum logic [1:0] {StIdle, StAw, StW} state_e;

    // ---------------- Packer ----------------
    logic [3:0]   pix_idx_q, pix_idx_d;
    logic [255:0] pix_buf_q, pix_buf_d;
    logic [3:0]   slot;
    logic         word_done;

    always_comb begin
        pix_idx_d = pix_idx_q;
        pix_buf_d = pix_buf_q;
        word_done = 1'b0;
        slot      = frame_start ? 4'd0 : pix_idx_q;
        if (frame_start) begin
            pix_idx_d = 4'd0;
        end
        if (pix_valid) begin
            pix_buf_d[{slot, 4'b0000} +: 16] = pix_data;
            word_done = (slot == 4'd15);
            pix_idx_d = slot + 4'd1;
        end
    end

    // ---------------- FIFO ----------------
    logic [255:0]    mem_q [FIFO_DEPTH];
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] count_q, count_d;
    logic [CntW-1:0] keep;
    logic            push, pop, drop, full;

    state_e     state_q, state_d;
    logic [3:0] beat_q, beat_d;

    assign pop  = (state_q == StW) && axi_wready;
    assign full = (count_q == DepthCnt) && !pop;
    assign push = word_done && !full;
    assign drop = word_done && full;

    // Words still owed to the in-flight burst; frame_start must not discard them.
    always_comb begin
        keep = '0;
        if (state_q == StAw) begin
            keep = BurstCnt;
        end else if (state_q == StW) begin
            keep = BurstCnt - CntW'(beat_q);
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PtrOne;
        end
        if (frame_start) begin
            wr_ptr_d = rd_ptr_q + PtrW'(keep);
            count_d  = keep - CntW'(pop);
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PtrOne;
            end
            count_d = count_q + CntW'(push) - CntW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= pix_buf_d;
        end
        pix_buf_q <= pix_buf_d;
    end

    // ---------------- Burst FSM ----------------
    logic [IdxW-1:0] word_idx_q, word_idx_d, next_idx;
    logic            idx_clr_q, idx_clr_d;
    logic            awvalid_q, awvalid_d;
    logic [27:0]     awaddr_q, awaddr_d;
    logic            overflow_q, overflow_d;
    logic            frame_done_q, frame_done_d;

    always_comb begin
        state_d      = state_q;
        beat_d       = beat_q;
        word_idx_d   = word_idx_q;
        idx_clr_d    = idx_clr_q;
        awvalid_d    = awvalid_q;
        awaddr_d     = awaddr_q;
        frame_done_d = 1'b0;
        overflow_d   = frame_start ? 1'b0 : (overflow_q | drop);
        next_idx     = word_idx_q + BurstIdx;
        unique case (state_q)
            StIdle: begin
                if (frame_start) begin
                    word_idx_d = '0;
                end else if (enable && (count_q >= BurstCnt)) begin
                    state_d   = StAw;
                    awvalid_d = 1'b1;
                    awaddr_d  = BASE_ADDR + 28'(word_idx_q) * AddrInc;
                end
            end
            StAw: begin
                if (frame_start) begin
                    idx_clr_d = 1'b1;
                end
                if (axi_awready) begin
                    awvalid_d = 1'b0;
                    beat_d    = 4'd0;
                    state_d   = StW;
                end
            end
            StW: begin
                if (frame_start) begin
                    idx_clr_d = 1'b1;
                end
                if (axi_wready) begin
                    beat_d = beat_q + 4'd1;
                    if (beat_q == LastBeat) begin
                        state_d = StIdle;
                        if (next_idx == FrameIdx) begin
                            word_idx_d   = '0;
                            frame_done_d = 1'b1;
                        end else begin
                            word_idx_d = next_idx;
                        end
                        // A frame_start seen during this burst restarts addressing now.
                        if (frame_start || idx_clr_q) begin
                            word_idx_d = '0;
                            idx_clr_d  = 1'b0;
                        end
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pix_idx_q    <= 4'd0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            state_q      <= StIdle;
            beat_q       <= 4'd0;
            word_idx_q   <= '0;
            idx_clr_q    <= 1'b0;
            awvalid_q    <= 1'b0;
            awaddr_q     <= BASE_ADDR;
            overflow_q   <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            pix_idx_q    <= pix_idx_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            state_q      <= state_d;
            beat_q       <= beat_d;
            word_idx_q   <= word_idx_d;
            idx_clr_q    <= idx_clr_d;
            awvalid_q    <= awvalid_d;
            awaddr_q     <= awaddr_d;
            overflow_q   <= overflow_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign axi_awaddr    = awaddr_q;
    assign axi_awvalid   = awvalid_q;
    assign axi_awuser_ap = 1'b0;
    assign axi_awuser_id = AXI_ID;
    assign axi_awlen     = 4'(BURST_LEN - 1);
    assign axi_wdata     = mem_q[rd_ptr_q];
    assign axi_wstrb     = '1;
    assign overflow      = overflow_q;
    assign frame_done    = frame_done_q;

endmodule

// File: tb/tb_frame_axi_writer.sv
// Directed bench for frame_axi_writer: packing, burst timing, frame restart and overflow.
module tb_frame_axi_writer;

    logic         clk = 1'b0;
    logic         rst, enable, frame_start, pix_valid;
    logic [15:0]  pix_data;
    logic [27:0]  axi_awaddr;
    logic         axi_awuser_ap;
    logic [3:0]   axi_awuser_id;
    logic [3:0]   axi_awlen;
    logic         axi_awvalid, axi_awready;
    logic [255:0] axi_wdata;
    logic [31:0]  axi_wstrb;
    logic         axi_wready, overflow, frame_done;

    int errors = 0;
    int checks = 0;

    frame_axi_writer #(
        .BURST_LEN   (8),
        .FIFO_DEPTH  (32),
        .BASE_ADDR   (28'h0000000),
        .ADDR_INC    (8),
        .FRAME_WORDS (16),
        .AXI_ID      (4'h5)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .enable        (enable),
        .frame_start   (frame_start),
        .pix_valid     (pix_valid),
        .pix_data      (pix_data),
        .axi_awaddr    (axi_awaddr),
        .axi_awuser_ap (axi_awuser_ap),
        .axi_awuser_id (axi_awuser_id),
        .axi_awlen     (axi_awlen),
        .axi_awvalid   (axi_awvalid),
        .axi_awready   (axi_awready),
        .axi_wdata     (axi_wdata),
        .axi_wstrb     (axi_wstrb),
        .axi_wready    (axi_wready),
        .overflow      (overflow),
        .frame_done    (frame_done)
    );

    always #5 clk = ~clk;

    // Bus observer: predicts at the falling edge what the next rising edge accepts.
    logic [27:0]  aws[$];
    logic [255:0] beats[$];
    int fd_cnt = 0;
    int bcnt   = 0;
    bit in_w   = 1'b0;

    always @(negedge clk) begin
        if (rst === 1'b0) begin
            if (in_w) begin
                if (axi_wready) begin
                    beats.push_back(axi_wdata);
                    bcnt <= bcnt + 1;
                    if (bcnt == 7) in_w <= 1'b0;
                end
            end else if (axi_awvalid && axi_awready) begin
                aws.push_back(axi_awaddr);
                in_w <= 1'b1;
                bcnt <= 0;
            end
            if (frame_done) fd_cnt <= fd_cnt + 1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [255:0] make_word(input logic [15:0] base);
        logic [255:0] w;
        for (int k = 0; k < 16; k++) w[16*k +: 16] = base + 16'(k);
        return w;
    endfunction

    function automatic logic [255:0] beat_at(input int j);
        return (j < beats.size()) ? beats[j] : {256{1'bx}};
    endfunction

    function automatic logic [27:0] aw_at(input int j);
        return (j < aws.size()) ? aws[j] : {28{1'bx}};
    endfunction

    task automatic send_pix(input int n, input logic [15:0] base);
        for (int i = 0; i < n; i++) begin
            pix_valid = 1'b1;
            pix_data  = base + 16'(i);
            tick();
        end
        pix_valid = 1'b0;
    endtask

    task automatic pulse_fs();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    task automatic clr_mon();
        aws.delete();
        beats.delete();
        fd_cnt = 0;
    endtask

    task automatic wait_beats(input string tag, input int target, input int budget);
        int n = 0;
        while (beats.size() < target && n < budget) begin
            tick();
            n++;
        end
        check(tag, 256'(beats.size() >= target), 256'd1);
    endtask

    task automatic check_beats(input string tag, input int first, input int n,
                               input logic [15:0] base);
        for (int j = 0; j < n; j++)
            check($sformatf("%s beat%0d", tag, j), beat_at(first + j),
                  make_word(base + 16'(16 * j)));
    endtask

    initial begin
        rst = 1'b1; enable = 1'b0; frame_start = 1'b0; pix_valid = 1'b0;
        pix_data = 16'h0; axi_awready = 1'b0; axi_wready = 1'b0;
        tick();
        tick();
        check("rst awvalid",    256'(axi_awvalid), 256'd0);
        check("rst awaddr",     256'(axi_awaddr), 256'd0);
        check("rst overflow",   256'(overflow), 256'd0);
        check("rst frame_done", 256'(frame_done), 256'd0);
        check("awlen",          256'(axi_awlen), 256'd7);
        check("wstrb",          256'(axi_wstrb), 256'hFFFF_FFFF);
        check("awuser_id",      256'(axi_awuser_id), 256'h5);
        check("awuser_ap",      256'(axi_awuser_ap), 256'd0);
        rst = 1'b0;
        enable = 1'b1; axi_awready = 1'b1; axi_wready = 1'b1;

        // One packed word, below burst threshold
        clr_mon();
        send_pix(16, 16'h0000);
        repeat (5) tick();
        check("t1 head word", axi_wdata,
              256'h000F_000E_000D_000C_000B_000A_0009_0008_0007_0006_0005_0004_0003_0002_0001_0000);
        check("t1 no awvalid", 256'(axi_awvalid), 256'd0);
        check("t1 no aw", 256'(aws.size()), 256'd0);

        // Single full burst, all ready
        pulse_fs();
        clr_mon();
        send_pix(128, 16'h1000);
        wait_beats("t2 beats seen", 8, 40);
        repeat (10) tick();
        check("t2 aw count", 256'(aws.size()), 256'd1);
        check("t2 awaddr", 256'(aw_at(0)), 256'd0);
        check("t2 beat count", 256'(beats.size()), 256'd8);
        check_beats("t2", 0, 8, 16'h1000);
        check("t2 no frame_done", 256'(fd_cnt), 256'd0);

        // Stale partial frame discarded; frame_start resets addressing
        pulse_fs();
        clr_mon();
        send_pix(20, 16'h3000);
        pulse_fs();
        send_pix(128, 16'h4000);
        wait_beats("t4 beats seen", 8, 40);
        repeat (10) tick();
        check("t4 aw count", 256'(aws.size()), 256'd1);
        check("t4 awaddr", 256'(aw_at(0)), 256'd0);
        check("t4 beat count", 256'(beats.size()), 256'd8);
        check_beats("t4", 0, 8, 16'h4000);

        // awready stalled, then wready toggling; second burst of frame wraps it
        clr_mon();
        axi_awready = 1'b0;
        send_pix(128, 16'h2000);
        for (int n = 0; n < 40 && axi_awvalid !== 1'b1; n++) tick();
        for (int n = 0; n < 5; n++) begin
            check($sformatf("t3 awvalid hold%0d", n), 256'(axi_awvalid), 256'd1);
            check($sformatf("t3 awaddr hold%0d", n), 256'(axi_awaddr), 256'd64);
            tick();
        end
        axi_awready = 1'b1;
        tick();
        axi_awready = 1'b0;
        for (int n = 0; n < 30; n++) begin
            axi_wready = (n % 2 == 0);
            tick();
        end
        axi_wready = 1'b1;
        repeat (5) tick();
        check("t3 aw count", 256'(aws.size()), 256'd1);
        check("t3 awaddr", 256'(aw_at(0)), 256'd64);
        check("t3 beat count", 256'(beats.size()), 256'd8);
        check_beats("t3", 0, 8, 16'h2000);
        check("t3 frame_done", 256'(fd_cnt), 256'd1);

        // Overflow with wready low; then drain shows 32 kept words and frame wrap
        pulse_fs();
        clr_mon();
        axi_awready = 1'b1;
        axi_wready  = 1'b0;
        send_pix(512, 16'h5000);
        check("t5 overflow at 32", 256'(overflow), 256'd0);
        send_pix(16, 16'h5200);
        tick();
        check("t5 overflow at 33", 256'(overflow), 256'd1);
        axi_wready = 1'b1;
        wait_beats("t5 beats seen", 32, 200);
        repeat (10) tick();
        check("t5 beat count", 256'(beats.size()), 256'd32);
        check_beats("t5", 0, 32, 16'h5000);
        check("t5 aw count", 256'(aws.size()), 256'd4);
        check("t5 awaddr0", 256'(aw_at(0)), 256'd0);
        check("t5 awaddr1", 256'(aw_at(1)), 256'd64);
        check("t5 awaddr2", 256'(aw_at(2)), 256'd0);
        check("t5 awaddr3", 256'(aw_at(3)), 256'd64);
        check("t5 frame_done", 256'(fd_cnt), 256'd2);
        check("t5 overflow sticky", 256'(overflow), 256'd1);
        pulse_fs();
        check("t5 overflow cleared", 256'(overflow), 256'd0);

        // frame_start mid-burst keeps only the committed words
        clr_mon();
        axi_wready = 1'b0;
        send_pix(160, 16'h6000);
        check("t6 in burst", 256'(in_w), 256'd1);
        pulse_fs();
        axi_wready = 1'b1;
        wait_beats("t6 beats seen", 8, 40);
        repeat (20) tick();
        check("t6 beat count", 256'(beats.size()), 256'd8);
        check("t6 aw count", 256'(aws.size()), 256'd1);
        check_beats("t6", 0, 8, 16'h6000);
        send_pix(128, 16'h7000);
        wait_beats("t6 next beats seen", 16, 40);
        repeat (5) tick();
        check("t6 next awaddr", 256'(aw_at(1)), 256'd0);
        check_beats("t6 next", 8, 8, 16'h7000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
